i2c_reg_bank: RTL and testbench
===============================

Name: i2c_reg_bank

Overview:
- Parametrised I2C slave plus register sequencer that serves NUM_CH read-back channels (power, FWD, REV, version, …) at contiguous 7-bit addresses BASE_ADDR to BASE_ADDR+NUM_CH-1.
- Adds three capabilities to the current version:
  - a coherent per-transfer snapshot, so high and low bytes always come from the same sample;
  - a master-write path that delivers a 16-bit word and a strobe to the fabric;
  - a parametrised deglitch length.
- Sits between the board-level SDA/SCL pins and the ADC/status logic; the top level builds the open-drain pad.

Parameters:
- BASE_ADDR, 7'h15, first slave address served.
- NUM_CH, 4, number of channels and addresses (1 to 16).
- DATA_W, 12, channel width (1 to 16); each channel is zero-extended to 16 bits on the wire.
- DG_LEN, 4, number of consecutive identical CLK samples needed to accept an SCL or SDA transition.

Ports:
- CLK, input, 1, system clock (12.288 MHz).
- reset, input, 1, asynchronous, active-high.
- scl_i, input, 1, raw SCL pin.
- sda_i, input, 1, raw SDA pin.
- sda_oe, output, 1, 1 = pull SDA low; 0 = release (high-Z).
- ch_data, input, NUM_CH*DATA_W, channel k occupies bits [k*DATA_W +: DATA_W].
- wr_data, output, 16, last word written by the master.
- wr_addr, output, 4, channel index of that write (address minus BASE_ADDR).
- wr_strobe, output, 1, one-CLK pulse when wr_data/wr_addr are valid.
- busy, output, 1, high from START until STOP.

Behaviour:
- Reset (async, active-high):
  - sda_oe=0, wr_data=0, wr_addr=0, wr_strobe=0, busy=0.
  - FSM goes to IDLE; deglitch filters preset to 1.
- Input conditioning:
  - Each input passes a 2-FF synchroniser, then a DG_LEN-deep filter; the filtered output changes only after DG_LEN identical samples.
  - Edges are detected on the filtered signals, one CLK after the filtered value changes.
- Bus conditions:
  - START: dg_sda falls while dg_scl=1.
  - STOP: dg_sda rises while dg_scl=1.
  - STOP from any state: sda_oe=0, go to IDLE, busy=0.
  - START from any state, including repeated start: go to ADDR, busy=1.
- Bit timing:
  - Receive bits are sampled on the dg_scl rising edge.
  - sda_oe changes only on the CLK after a dg_scl falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 7 address bits plus R/W, MSB first. On the 8th bit:
    - if addr is within [BASE_ADDR, BASE_ADDR+NUM_CH-1], latch idx = addr - BASE_ADDR and go to ACK_A;
    - otherwise go to WAIT with SDA never driven.
  - ACK_A: drive SDA low for the 9th clock.
    - On read, snapshot ch_data[idx] zero-extended into a 16-bit shift register at the same CLK as the 8th-bit sample.
    - Then go to TX_HI (read) or RX_HI (write).
  - TX_HI / TX_LO: drive 8 bits MSB first; sda_oe = ~bit.
  - MACK_HI / MACK_LO: release SDA and sample the master's ACK.
    - NACK after the high byte: go to WAIT.
    - After the low byte: go to WAIT regardless. There is no auto-increment, and no further bytes are driven.
  - RX_HI / RX_LO: shift in a data byte, then ACK it (SACK_HI / SACK_LO).
    - On the 8th bit of the low byte, register wr_data={hi,lo} and wr_addr=idx, and pulse wr_strobe for exactly one CLK.
    - After SACK_LO, go to WAIT; any third byte is NACKed.
  - WAIT: SDA released; only START or STOP are acted on.
- Boundary rules:
  - STOP after only the high write byte: no wr_strobe; wr_data is unchanged.
  - ch_data changing during a read has no effect once the snapshot is taken.
  - Reset mid-ACK releases SDA immediately (asynchronous).
  - General-call address 0x00 is never ACKed.

Test Plan:
- Read channel: ch1=12'hABC, master reads 0x16 → ACK; bytes 0x0A, 0xBC; after master NACK, SDA released until STOP.
- Coherent snapshot: ch0 changes from 12'h0FF to 12'h100 during the high byte of a read at 0x15 → bytes 0x00, 0xFF, never 0x00/0x00 or 0x01/0xFF.
- Write: master writes 0x17 with 0x12, 0x34 → both bytes ACKed; exactly one wr_strobe pulse with wr_data=16'h1234, wr_addr=2; a third byte 0x56 is NACKed.
- Address miss and partial write: address 0x19 (NUM_CH=4) → no ACK and sda_oe stays 0. Write 0x15 with a single byte then STOP → no wr_strobe.
- Glitch and repeated start: a 2-CLK SCL pulse (DG_LEN=4) is ignored with no bit shifted; a repeated START mid-read followed by a read of 0x18 returns ch3's value.
- Async reset asserted while the slave drives ACK → sda_oe=0 within the same CLK; busy=0. After release, the next read of 0x15 behaves normally.

Source files
------------

// File: rtl/i2c_reg_bank.sv
// I2C slave serving NUM_CH read-back channels with coherent snapshots
// and a 16-bit master-write path to the fabric.
module i2c_reg_bank_dg #(
  parameter int unsigned DG_LEN = 4
) (
  input  logic CLK,
  input  logic reset,
  input  logic d,
  output logic q
);
  localparam int unsigned CW = (DG_LEN > 1) ? $clog2(DG_LEN) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync <= 2'b11;
      q    <= 1'b1;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], d};
      if (sync[1] != q) begin
        if (cnt == CW'(DG_LEN - 1)) begin
          q   <= sync[1];
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module i2c_reg_bank #(
  parameter logic [6:0]  BASE_ADDR = 7'h15,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned DG_LEN    = 4
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     scl_i,
  input  logic                     sda_i,
  output logic                     sda_oe,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [15:0]              wr_data,
  output logic [3:0]               wr_addr,
  output logic                     wr_strobe,
  output logic                     busy
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_A,
    TX_HI, MACK_HI, TX_LO, MACK_LO,
    RX_HI, SACK_HI, RX_LO, SACK_LO,
    WAIT
  } state_t;

  state_t      state;
  logic        dg_scl, dg_sda;
  logic        scl_d, sda_d;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_sh;
  logic [15:0] tx_sh;
  logic [7:0]  hi_byte;
  logic [3:0]  idx;
  logic        rw;
  logic        phase;
  logic        mack;
  logic [15:0] chan [16];

  i2c_reg_bank_dg #(.DG_LEN(DG_LEN)) u_dg_scl (
    .CLK(CLK), .reset(reset), .d(scl_i), .q(dg_scl)
  );
  i2c_reg_bank_dg #(.DG_LEN(DG_LEN)) u_dg_sda (
    .CLK(CLK), .reset(reset), .d(sda_i), .q(dg_sda)
  );

  for (genvar k = 0; k < 16; k++) begin : g_ch
    if (k < NUM_CH) begin : g_on
      assign chan[k] = 16'(ch_data[k*DATA_W +: DATA_W]);
    end else begin : g_off
      assign chan[k] = '0;
    end
  end

  logic       scl_rise, scl_fall;
  logic       start_c, stop_c;
  logic [7:0] rx_byte;
  logic [7:0] off;
  logic       hit;

  assign scl_rise = dg_scl & ~scl_d;
  assign scl_fall = ~dg_scl & scl_d;
  assign start_c  = ~dg_sda & sda_d & dg_scl;
  assign stop_c   = dg_sda & ~sda_d & dg_scl;
  assign rx_byte  = {rx_sh, dg_sda};
  // Wrap-around subtraction makes addresses below BASE_ADDR miss too
  assign off = {1'b0, rx_sh} - {1'b0, BASE_ADDR};
  assign hit = (off < 8'(NUM_CH)) && (rx_sh != 7'd0);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      scl_d     <= 1'b1;
      sda_d     <= 1'b1;
      sda_oe    <= 1'b0;
      wr_data   <= '0;
      wr_addr   <= '0;
      wr_strobe <= 1'b0;
      busy      <= 1'b0;
      bit_cnt   <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      hi_byte   <= '0;
      idx       <= '0;
      rw        <= 1'b0;
      phase     <= 1'b0;
      mack      <= 1'b0;
    end else begin
      scl_d     <= dg_scl;
      sda_d     <= dg_sda;
      wr_strobe <= 1'b0;
      if (stop_c) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (start_c) begin
        state   <= ADDR;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
        bit_cnt <= '0;
      end else begin
        unique case (state)
          ADDR: if (scl_rise) begin
            rx_sh   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              if (hit) begin
                idx   <= off[3:0];
                rw    <= dg_sda;
                phase <= 1'b0;
                state <= ACK_A;
                if (dg_sda) tx_sh <= chan[off[3:0]];
              end else begin
                state <= WAIT;
              end
            end
          end
          ACK_A: if (scl_fall) begin
            if (!phase) begin
              sda_oe <= 1'b1;
              phase  <= 1'b1;
            end else begin
              bit_cnt <= '0;
              if (rw) begin
                sda_oe <= ~tx_sh[15];
                state  <= TX_HI;
              end else begin
                sda_oe <= 1'b0;
                state  <= RX_HI;
              end
            end
          end
          TX_HI, TX_LO: if (scl_fall) begin
            bit_cnt <= bit_cnt + 1'b1;
            tx_sh   <= tx_sh << 1;
            if (bit_cnt == 3'd7) begin
              sda_oe <= 1'b0;
              state  <= (state == TX_HI) ? MACK_HI : MACK_LO;
            end else begin
              sda_oe <= ~tx_sh[14];
            end
          end
          MACK_HI: begin
            if (scl_rise) begin
              mack <= ~dg_sda;
            end else if (scl_fall) begin
              bit_cnt <= '0;
              if (mack) begin
                sda_oe <= ~tx_sh[15];
                state  <= TX_LO;
              end else begin
                state <= WAIT;
              end
            end
          end
          MACK_LO: if (scl_fall) state <= WAIT;
          RX_HI, RX_LO: if (scl_rise) begin
            rx_sh   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              phase <= 1'b0;
              if (state == RX_HI) begin
                hi_byte <= rx_byte;
                state   <= SACK_HI;
              end else begin
                wr_data   <= {hi_byte, rx_byte};
                wr_addr   <= idx;
                wr_strobe <= 1'b1;
                state     <= SACK_LO;
              end
            end
          end
          SACK_HI, SACK_LO: if (scl_fall) begin
            if (!phase) begin
              sda_oe <= 1'b1;
              phase  <= 1'b1;
            end else begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= (state == SACK_HI) ? RX_LO : WAIT;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_reg_bank.sv
// Bench for i2c_reg_bank: open-drain bus master, vector table,
// hand-written corner sequences and a randomized model check.
module tb_i2c_reg_bank;
  localparam logic [6:0] BASE = 7'h15;
  localparam int NCH = 4;
  localparam int DW  = 12;
  localparam int Q   = 12;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic [NCH*DW-1:0] ch_data = '0;
  logic scl_i, sda_i, sda_oe, wr_strobe, busy;
  logic [15:0] wr_data;
  logic [3:0]  wr_addr;

  assign scl_i = scl_m;
  assign sda_i = sda_m & ~sda_oe;

  always #5 CLK = ~CLK;

  i2c_reg_bank #(
    .BASE_ADDR(BASE), .NUM_CH(NCH), .DATA_W(DW), .DG_LEN(4)
  ) dut (
    .CLK(CLK), .reset(reset), .scl_i(scl_i), .sda_i(sda_i),
    .sda_oe(sda_oe), .ch_data(ch_data), .wr_data(wr_data),
    .wr_addr(wr_addr), .wr_strobe(wr_strobe), .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  int strobes = 0;
  int long_pulse = 0;
  int oe_cnt = 0;
  logic prev_st = 1'b0;
  logic [15:0] cap_wd = '0;
  logic [3:0]  cap_wa = '0;

  always @(negedge CLK) begin
    if (wr_strobe) begin
      strobes++;
      cap_wd = wr_data;
      cap_wa = wr_addr;
      if (prev_st) long_pulse++;
    end
    prev_st = wr_strobe;
    if (sda_oe) oe_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: sim time limit reached, required finish earlier");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic bit_x(input logic b, output logic r);
    sda_m = b;
    wq(Q);
    scl_m = 1'b1;
    wq(Q);
    r = sda_i;
    wq(Q);
    scl_m = 1'b0;
    wq(Q);
  endtask

  task automatic start_c();
    sda_m = 1'b1;
    wq(Q);
    scl_m = 1'b1;
    wq(Q);
    sda_m = 1'b0;
    wq(Q);
    scl_m = 1'b0;
    wq(Q);
  endtask

  task automatic stop_c();
    sda_m = 1'b0;
    wq(Q);
    scl_m = 1'b1;
    wq(Q);
    sda_m = 1'b1;
    wq(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_x(b[i], r);
    bit_x(1'b1, r);
    ack = ~r;
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic ack_it);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, r);
      b[i] = r;
    end
    bit_x(~ack_it, r);
  endtask

  task automatic xfer(input logic [6:0] a, input logic rw,
                      input logic [15:0] wd, output logic ack,
                      output logic wack, output logic [15:0] rd);
    logic [7:0] h, l;
    logic a1, a2;
    h = '0; l = '0; a1 = 1'b0; a2 = 1'b0;
    start_c();
    send_byte({a, rw}, ack);
    if (ack) begin
      if (rw) begin
        recv_byte(h, 1'b1);
        recv_byte(l, 1'b0);
      end else begin
        send_byte(wd[15:8], a1);
        send_byte(wd[7:0], a2);
      end
    end
    stop_c();
    rd = {h, l};
    wack = a1 & a2;
  endtask

  task automatic run_check(input string nm, input logic [6:0] a,
                           input logic rw, input logic [15:0] wd,
                           input logic [47:0] ch, input logic eack,
                           input logic [15:0] erd, input logic [3:0] eidx);
    int s0, o0;
    logic ack, wack;
    logic [15:0] rd;
    ch_data = ch;
    s0 = strobes;
    o0 = oe_cnt;
    xfer(a, rw, wd, ack, wack, rd);
    chk({nm, "_ack"}, 32'(ack), 32'(eack));
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_sda_rel"}, 32'(sda_oe), 32'd0);
    if (!eack) begin
      chk({nm, "_no_oe"}, 32'(oe_cnt - o0), 32'd0);
      chk({nm, "_no_strobe"}, 32'(strobes - s0), 32'd0);
    end else if (rw) begin
      chk({nm, "_rd"}, 32'(rd), 32'(erd));
      chk({nm, "_rd_no_strobe"}, 32'(strobes - s0), 32'd0);
    end else begin
      chk({nm, "_wack"}, 32'(wack), 32'd1);
      chk({nm, "_strobes"}, 32'(strobes - s0), 32'd1);
      chk({nm, "_wdata"}, 32'(cap_wd), 32'(wd));
      chk({nm, "_waddr"}, 32'(cap_wa), 32'(eidx));
    end
  endtask

  function automatic logic m_hit(input logic [6:0] a);
    return (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + NCH);
  endfunction

  function automatic logic [15:0] m_val(input logic [47:0] ch,
                                        input logic [6:0] a);
    int off;
    logic [47:0] t;
    off = int'(a) - int'(BASE);
    t = ch >> (off * DW);
    return 16'(t[DW-1:0]);
  endfunction

  typedef struct {
    logic [6:0]  a;
    logic        rw;
    logic [15:0] wd;
    logic [47:0] ch;
    logic        ack;
    logic [15:0] rd;
    logic [3:0]  idx;
  } vec_t;

  vec_t vt[7];

  initial begin
    logic ack, a2, a3, r;
    logic [7:0] hb, lb, b8;
    logic [15:0] rd;
    int s0;

    vt[0] = '{7'h16, 1'b1, 16'h0000, 48'h000_000_ABC_000, 1'b1, 16'h0ABC, 4'd1};
    vt[1] = '{7'h18, 1'b1, 16'h0000, 48'h5A5_000_000_000, 1'b1, 16'h05A5, 4'd3};
    vt[2] = '{7'h17, 1'b0, 16'h1234, 48'h000_000_000_000, 1'b1, 16'h0000, 4'd2};
    vt[3] = '{7'h19, 1'b1, 16'h0000, 48'hFFF_FFF_FFF_FFF, 1'b0, 16'h0000, 4'd0};
    vt[4] = '{7'h00, 1'b0, 16'h5555, 48'h000_000_000_000, 1'b0, 16'h0000, 4'd0};
    vt[5] = '{7'h14, 1'b1, 16'h0000, 48'h111_222_333_444, 1'b0, 16'h0000, 4'd0};
    vt[6] = '{7'h15, 1'b1, 16'h0000, 48'h123_456_789_FFF, 1'b1, 16'h0FFF, 4'd0};

    wq(5);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    wq(20);

    for (int i = 0; i < 7; i++)
      run_check($sformatf("vec%0d", i), vt[i].a, vt[i].rw, vt[i].wd,
                vt[i].ch, vt[i].ack, vt[i].rd, vt[i].idx);

    // snapshot coherence: ch0 changes mid high byte
    ch_data = 48'h000_000_000_0FF;
    start_c();
    send_byte({7'h15, 1'b1}, ack);
    chk("snap_ack", 32'(ack), 32'd1);
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, r);
      hb[i] = r;
      if (i == 4) ch_data = 48'h000_000_000_100;
    end
    bit_x(1'b0, r);
    recv_byte(lb, 1'b0);
    stop_c();
    chk("snap_hi", 32'(hb), 32'h00);
    chk("snap_lo", 32'(lb), 32'hFF);

    // write with a third byte that must be NACKed
    s0 = strobes;
    start_c();
    send_byte({7'h17, 1'b0}, ack);
    send_byte(8'h12, a2);
    send_byte(8'h34, a3);
    chk("w3_ack", 32'({ack, a2, a3}), 32'b111);
    send_byte(8'h56, a3);
    chk("w3_third_nack", 32'(a3), 32'd0);
    stop_c();
    chk("w3_strobes", 32'(strobes - s0), 32'd1);
    chk("w3_pulse_width", 32'(long_pulse), 32'd0);
    chk("w3_wdata", 32'(cap_wd), 32'h1234);
    chk("w3_waddr", 32'(cap_wa), 32'd2);

    // partial write: one byte then STOP
    s0 = strobes;
    start_c();
    send_byte({7'h15, 1'b0}, ack);
    send_byte(8'hAB, a2);
    stop_c();
    chk("pw_acks", 32'({ack, a2}), 32'b11);
    chk("pw_no_strobe", 32'(strobes - s0), 32'd0);
    chk("pw_wdata_kept", 32'(wr_data), 32'h1234);

    // 2-CLK SCL glitch after START is ignored
    ch_data = 48'h000_000_3C7_000;
    start_c();
    scl_m = 1'b1;
    wq(2);
    scl_m = 1'b0;
    wq(Q);
    send_byte({7'h16, 1'b1}, ack);
    chk("gl_ack", 32'(ack), 32'd1);
    recv_byte(hb, 1'b1);
    recv_byte(lb, 1'b0);
    stop_c();
    chk("gl_rd", 32'({hb, lb}), 32'h03C7);

    // repeated START mid-read, then read ch3
    ch_data = 48'h9E2_000_000_111;
    start_c();
    send_byte({7'h15, 1'b1}, ack);
    recv_byte(hb, 1'b0);
    chk("rs_hi", 32'(hb), 32'h01);
    chk("rs_busy", 32'(busy), 32'd1);
    start_c();
    send_byte({7'h18, 1'b1}, ack);
    chk("rs_ack", 32'(ack), 32'd1);
    recv_byte(hb, 1'b1);
    recv_byte(lb, 1'b0);
    stop_c();
    chk("rs_rd", 32'({hb, lb}), 32'h09E2);

    // async reset while the slave drives the address ACK
    ch_data = 48'h000_000_000_2B4;
    start_c();
    b8 = {7'h15, 1'b1};
    for (int i = 7; i >= 0; i--) bit_x(b8[i], r);
    sda_m = 1'b1;
    wq(Q);
    chk("ra_ack_driven", 32'(sda_oe), 32'd1);
    reset = 1'b1;
    #1;
    chk("ra_oe_released", 32'(sda_oe), 32'd0);
    chk("ra_busy", 32'(busy), 32'd0);
    wq(3);
    reset = 1'b0;
    wq(Q);
    stop_c();
    run_check("ra_after", 7'h15, 1'b1, 16'h0, 48'h000_000_000_2B4,
              1'b1, 16'h02B4, 4'd0);

    // randomized transfers against the address/value model
    for (int n = 0; n < 8; n++) begin
      logic [6:0]  a;
      logic        rw;
      logic [15:0] wd;
      logic [47:0] ch;
      a  = 7'($urandom_range(int'(BASE) + NCH, int'(BASE) - 1));
      rw = 1'($urandom_range(1, 0));
      wd = 16'($urandom);
      ch = {16'($urandom), 32'($urandom)};
      run_check($sformatf("rnd%0d", n), a, rw, wd, ch, m_hit(a),
                m_val(ch, a), 4'(int'(a) - int'(BASE)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
